// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera frame-buffer write controller.
package cam_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CFG      = 2'd1,
      ST_WAIT_SOF = 2'd2,
      ST_ACTIVE   = 2'd3
   } cam_state_e;

   localparam int unsigned H_ACTIVE_DEF    = 640;
   localparam int unsigned V_ACTIVE_DEF    = 480;
   localparam int unsigned FRAME_PIXELS    = H_ACTIVE_DEF * V_ACTIVE_DEF;
   localparam int unsigned CFG_TIMEOUT_DEF = 12_500_000;

   function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned v);
      return h * v;
   endfunction

endpackage

// File: rtl/cam_rd_pipe.sv
// Read-valid shift register: tracks which FIFO reads belong to the current
// frame and registers the returned pixel for the frame-buffer write port.
module cam_rd_pipe #(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned DATA_WIDTH = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_flush,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_launch,
   output logic                  o_we,
   output logic [DATA_WIDTH-1:0] o_wdata
);

   logic [RD_LATENCY-1:0] vld_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   // A flush kills the read that is just reaching the tap as well.
   assign o_launch = vld_q[RD_LATENCY-1] && !i_flush;
   assign o_we     = we_q;
   assign o_wdata  = wdata_q;

   // Shift valid tags along with the FIFO read latency; flush drops them all.
   always_ff @(posedge i_clk) begin
      if (!i_rstn || i_flush) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= i_push;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   // Register the write strobe and capture data when a tagged read returns.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         we_q <= o_launch;
         if (o_launch) begin
            wdata_q <= i_data;
         end
      end
   end

endmodule

// File: rtl/cam_fb_wr_ctrl.sv
// Camera bring-up sequencer and output-FIFO to frame-buffer write controller.
module cam_fb_wr_ctrl
   import cam_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
   parameter int unsigned ADDR_WIDTH  = 19,
   parameter int unsigned DATA_WIDTH  = 12,
   parameter int unsigned RD_LATENCY  = 1,
   parameter int unsigned CFG_TIMEOUT = CFG_TIMEOUT_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_enable,
   output logic                  o_cfg_init,
   input  logic                  i_cfg_done,
   input  logic                  i_sof,
   output logic                  o_obuf_rd,
   input  logic [DATA_WIDTH-1:0] i_obuf_data,
   input  logic                  i_obuf_empty,
   output logic                  o_fb_we,
   output logic [ADDR_WIDTH-1:0] o_fb_addr,
   output logic [DATA_WIDTH-1:0] o_fb_wdata,
   output logic                  o_frame_done,
   output logic                  o_frame_err,
   output logic                  o_cfg_err,
   output logic                  o_busy
);

   localparam int unsigned FRAME = frame_pixels(H_ACTIVE, V_ACTIVE);
   localparam int unsigned CW    = ADDR_WIDTH + 1;
   localparam int unsigned TW    = (CFG_TIMEOUT > 1) ? $clog2(CFG_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(CFG_TIMEOUT - 1);

   cam_state_e            state_q, state_d;
   logic [CW-1:0]         issue_q, issue_d;
   logic [CW-1:0]         wr_q, wr_d;
   logic [TW-1:0]         cfg_cnt_q, cfg_cnt_d;
   logic                  drop_q, drop_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  done_q;
   logic                  flush, push, launch, rd;

   // Reads are pulled from the FIFO in WAIT_SOF (discarded) and ACTIVE (kept).
   assign rd    = !i_obuf_empty &&
                  ((state_q == ST_WAIT_SOF) ||
                   ((state_q == ST_ACTIVE) && (issue_q < CW'(FRAME))));
   assign push  = rd && (state_q == ST_ACTIVE);
   assign flush = i_sof && (((state_q == ST_WAIT_SOF) && i_enable) || (state_q == ST_ACTIVE));

   assign o_obuf_rd    = rd;
   assign o_cfg_init   = (state_q == ST_CFG) && !drop_q;
   assign o_cfg_err    = (state_q == ST_CFG) && !i_cfg_done && !drop_q && (cfg_cnt_q == TMAX);
   assign o_frame_err  = (state_q == ST_ACTIVE) && i_sof && !done_q;
   assign o_frame_done = done_q;
   assign o_fb_addr    = addr_q;
   assign o_busy       = (state_q != ST_IDLE);

   cam_rd_pipe #(
      .RD_LATENCY (RD_LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rd_pipe (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_flush  (flush),
      .i_push   (push),
      .i_data   (i_obuf_data),
      .o_launch (launch),
      .o_we     (o_fb_we),
      .o_wdata  (o_fb_wdata)
   );

   // Next-state, config timeout/retry and frame counters.
   always_comb begin
      state_d   = state_q;
      issue_d   = issue_q;
      wr_d      = wr_q;
      cfg_cnt_d = cfg_cnt_q;
      drop_d    = drop_q;
      case (state_q)
         ST_IDLE: begin
            cfg_cnt_d = '0;
            drop_d    = 1'b0;
            if (i_enable) begin
               state_d = i_cfg_done ? ST_WAIT_SOF : ST_CFG;
            end
         end
         ST_CFG: begin
            if (i_cfg_done) begin
               state_d   = ST_WAIT_SOF;
               cfg_cnt_d = '0;
               drop_d    = 1'b0;
            end else if (drop_q) begin
               drop_d = 1'b0;
            end else if (cfg_cnt_q == TMAX) begin
               cfg_cnt_d = '0;
               drop_d    = 1'b1;
            end else begin
               cfg_cnt_d = cfg_cnt_q + 1'b1;
            end
         end
         ST_WAIT_SOF: begin
            if (!i_enable) begin
               state_d = ST_IDLE;
            end else if (i_sof) begin
               state_d = ST_ACTIVE;
               issue_d = '0;
               wr_d    = '0;
            end
         end
         ST_ACTIVE: begin
            if (rd) begin
               issue_d = issue_q + 1'b1;
            end
            if (launch) begin
               wr_d = wr_q + 1'b1;
            end
            // SOF restarts the frame whether or not it lands on the last write.
            if (i_sof) begin
               issue_d = '0;
               wr_d    = '0;
            end else if (done_q) begin
               state_d = i_enable ? ST_WAIT_SOF : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q   <= ST_IDLE;
         issue_q   <= '0;
         wr_q      <= '0;
         cfg_cnt_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         issue_q   <= issue_d;
         wr_q      <= wr_d;
         cfg_cnt_q <= cfg_cnt_d;
         drop_q    <= drop_d;
      end
   end

   // Address and frame-done are registered alongside the pipe's write strobe.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         addr_q <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= launch && (wr_q == CW'(FRAME - 1));
         if (launch) begin
            addr_q <= wr_q[ADDR_WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_cam_fb_wr_ctrl.sv
// Directed bench for cam_fb_wr_ctrl: cycle vector table plus frame sequences
// driven through a small FIFO model with configurable read latency.
module tb_cam_fb_wr_ctrl;

   localparam int unsigned H     = 4;
   localparam int unsigned V     = 2;
   localparam int unsigned FRAME = H * V;
   localparam int unsigned AW    = 3;
   localparam int unsigned DW    = 12;
   localparam int unsigned LAT   = 3;
   localparam int unsigned TO    = 100;

   logic          i_clk = 1'b0;
   logic          i_rstn, i_enable, i_cfg_done, i_sof, i_obuf_empty;
   logic [DW-1:0] i_obuf_data;
   logic          o_cfg_init, o_obuf_rd, o_fb_we, o_frame_done, o_frame_err, o_cfg_err, o_busy;
   logic [AW-1:0] o_fb_addr;
   logic [DW-1:0] o_fb_wdata;

   cam_fb_wr_ctrl #(
      .H_ACTIVE    (H),
      .V_ACTIVE    (V),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .RD_LATENCY  (LAT),
      .CFG_TIMEOUT (TO)
   ) dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_enable     (i_enable),
      .o_cfg_init   (o_cfg_init),
      .i_cfg_done   (i_cfg_done),
      .i_sof        (i_sof),
      .o_obuf_rd    (o_obuf_rd),
      .i_obuf_data  (i_obuf_data),
      .i_obuf_empty (i_obuf_empty),
      .o_fb_we      (o_fb_we),
      .o_fb_addr    (o_fb_addr),
      .o_fb_wdata   (o_fb_wdata),
      .o_frame_done (o_frame_done),
      .o_frame_err  (o_frame_err),
      .o_cfg_err    (o_cfg_err),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic rstn, en, cdone, sof, empty;
      logic init, busy, rd, cerr, ferr;
   } vec_t;

   vec_t          tbl [16];
   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] q [$];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] dly [LAT];
   int            wr_idx = 0;
   int            nfd = 0;
   int            cyc_n = 0;
   int            rd_first = -1;
   int            we_first = -1;
   bit            lat_arm = 0;
   bit            gap_en = 0;
   bit            ferr_ok = 0;
   bit            sof_on_done = 0;
   bit            sof_fired = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_init"}, o_cfg_init, 0);
      chk({nm, "_rd"}, o_obuf_rd, 0);
      chk({nm, "_we"}, o_fb_we, 0);
      chk({nm, "_addr"}, o_fb_addr, 0);
      chk({nm, "_wdata"}, o_fb_wdata, 0);
      chk({nm, "_done"}, o_frame_done, 0);
      chk({nm, "_ferr"}, o_frame_err, 0);
      chk({nm, "_cerr"}, o_cfg_err, 0);
      chk({nm, "_busy"}, o_busy, 0);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rstn = 1'b0; i_enable = 1'b0; i_cfg_done = 1'b0; i_sof = 1'b0;
      i_obuf_empty = 1'b1; i_obuf_data = '0;
      q.delete(); exp_q.delete(); wr_idx = 0; gap_en = 0;
      for (int i = 0; i < LAT; i++) dly[i] = 12'hEEE;
      repeat (2) @(negedge i_clk);
   endtask

   task automatic set_exp(input logic [DW-1:0] base, input int n);
      exp_q.delete();
      for (int k = 0; k < n; k++) exp_q.push_back(base + DW'(k));
      wr_idx = 0;
   endtask

   task automatic push_words(input logic [DW-1:0] base, input int n);
      for (int k = 0; k < n; k++) q.push_back(base + DW'(k));
      i_obuf_empty = 1'b0;
   endtask

   // One clock with the FIFO model; called just after a negedge.
   task automatic cyc();
      logic rd_now;
      #1;
      cyc_n++;
      rd_now = o_obuf_rd;
      chk("rd_while_empty", rd_now & i_obuf_empty, 0);
      chk("done_without_we", o_frame_done & ~o_fb_we, 0);
      if (!ferr_ok) chk("spurious_frame_err", o_frame_err, 0);
      if (lat_arm && rd_now && rd_first < 0) rd_first = cyc_n;
      if (lat_arm && o_fb_we && we_first < 0) we_first = cyc_n;
      if (o_fb_we) begin
         if (wr_idx >= exp_q.size()) begin
            chk("unexpected_write", 1, 0);
         end else begin
            chk("wr_addr", o_fb_addr, wr_idx);
            chk("wr_data", o_fb_wdata, exp_q[wr_idx]);
            chk("wr_done", o_frame_done, (wr_idx == FRAME - 1));
         end
         wr_idx++;
      end
      if (o_frame_done) nfd++;
      if (o_frame_done && sof_on_done) begin
         i_sof = 1'b1;
         #1;
         chk("sof_on_last_no_err", o_frame_err, 0);
         sof_on_done = 0;
         sof_fired = 1;
      end
      @(posedge i_clk);
      for (int i = LAT - 1; i > 0; i--) dly[i] = dly[i-1];
      if (rd_now && q.size() > 0) dly[0] = q.pop_front();
      else dly[0] = 12'hEEE;
      @(negedge i_clk);
      if (sof_fired) begin
         i_sof = 1'b0;
         sof_fired = 0;
      end
      i_obuf_data  = dly[LAT-1];
      i_obuf_empty = (q.size() == 0) || (gap_en && ($urandom_range(0, 1) == 1));
   endtask

   task automatic wait_writes(input int n, input int budget, input string nm);
      int k = 0;
      while (wr_idx < n && k < budget) begin
         cyc();
         k++;
      end
      chk({nm, "_timeout"}, (wr_idx >= n), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int nfd0;
      //                rst en cd sof emp | init busy rd cerr ferr
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
      tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0};
      tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0};
      tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0};
      tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
      tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};
      tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0};
      tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0};
      tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0};
      tbl[10] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0};
      tbl[11] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b1};
      tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0};
      tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0};
      tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0};
      tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};

      // Reset state.
      do_reset();
      #1;
      chk_all_zero("reset");

      // Cycle-level control vectors.
      for (int i = 0; i < 16; i++) begin
         i_rstn = tbl[i].rstn; i_enable = tbl[i].en; i_cfg_done = tbl[i].cdone;
         i_sof = tbl[i].sof; i_obuf_empty = tbl[i].empty;
         #1;
         chk($sformatf("tbl%0d_init", i), o_cfg_init, tbl[i].init);
         chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].busy);
         chk($sformatf("tbl%0d_rd", i), o_obuf_rd, tbl[i].rd);
         chk($sformatf("tbl%0d_cerr", i), o_cfg_err, tbl[i].cerr);
         chk($sformatf("tbl%0d_ferr", i), o_frame_err, tbl[i].ferr);
         chk($sformatf("tbl%0d_we", i), o_fb_we, 0);
         chk($sformatf("tbl%0d_done", i), o_frame_done, 0);
         @(negedge i_clk);
      end

      // Config done at cycle 50.
      do_reset();
      i_rstn = 1'b1; i_enable = 1'b1;
      #1;
      chk("cfg50_c0_busy", o_busy, 0);
      for (int c = 1; c <= 50; c++) begin
         @(negedge i_clk);
         if (c == 50) i_cfg_done = 1'b1;
         #1;
         chk($sformatf("cfg50_c%0d_init", c), o_cfg_init, 1);
         chk($sformatf("cfg50_c%0d_cerr", c), o_cfg_err, 0);
      end
      @(negedge i_clk);
      i_obuf_empty = 1'b0;
      #1;
      chk("cfg50_c51_init", o_cfg_init, 0);
      chk("cfg50_c51_busy", o_busy, 1);
      chk("cfg50_c51_rd", o_obuf_rd, 1);

      // Config timeout and retry.
      do_reset();
      i_rstn = 1'b1; i_enable = 1'b1;
      for (int c = 1; c <= 210; c++) begin
         @(negedge i_clk);
         #1;
         chk($sformatf("cto_c%0d_cerr", c), o_cfg_err, (c == 100 || c == 201));
         chk($sformatf("cto_c%0d_init", c), o_cfg_init, !(c == 101 || c == 202));
      end

      // Stale words discarded, then one clean frame.
      do_reset();
      i_rstn = 1'b1; i_enable = 1'b1; i_cfg_done = 1'b1;
      cyc();
      push_words(12'hA01, 5);
      repeat (12) cyc();
      i_sof = 1'b1;
      set_exp(12'h001, FRAME);
      nfd0 = nfd;
      cyc();
      i_sof = 1'b0;
      lat_arm = 1;
      push_words(12'h001, FRAME);
      wait_writes(FRAME, 40, "frame1");
      lat_arm = 0;
      chk("frame1_done_cnt", nfd - nfd0, 1);
      chk("rd_to_we_latency", we_first - rd_first, LAT + 1);
      #1;
      chk("frame1_busy_after", o_busy, 1);

      // SOF after three writes: error, restart at address 0.
      i_sof = 1'b1;
      set_exp(12'h101, 3);
      cyc();
      i_sof = 1'b0;
      push_words(12'h101, 3);
      wait_writes(3, 30, "partial");
      repeat (2) cyc();
      i_sof = 1'b1;
      #1;
      chk("short_frame_err", o_frame_err, 1);
      ferr_ok = 1;
      cyc();
      ferr_ok = 0;
      i_sof = 1'b0;
      set_exp(12'h201, FRAME);
      nfd0 = nfd;
      push_words(12'h201, FRAME);
      wait_writes(FRAME, 40, "after_err");
      chk("after_err_done_cnt", nfd - nfd0, 1);

      // Back-to-back frames with random FIFO gaps, enable drop, SOF on last write.
      gap_en = 1;
      for (int f = 0; f < 12; f++) begin
         if (f != 9) begin
            i_sof = 1'b1;
            cyc();
            i_sof = 1'b0;
         end
         set_exp(12'h300 + DW'(f * 16), FRAME);
         nfd0 = nfd;
         push_words(12'h300 + DW'(f * 16), FRAME);
         if (f == 5) begin
            i_enable = 1'b0;
            wait_writes(4, 100, "gap_half");
            #1;
            chk("en_drop_busy_mid", o_busy, 1);
         end
         if (f == 8) sof_on_done = 1;
         wait_writes(FRAME, 100, $sformatf("gap_f%0d", f));
         chk($sformatf("gap_f%0d_done_cnt", f), nfd - nfd0, 1);
         if (f == 5) begin
            #1;
            chk("en_drop_idle", o_busy, 0);
            i_enable = 1'b1;
            cyc();
         end
      end
      gap_en = 0;

      // Reset pulse mid-frame with reads in flight.
      i_sof = 1'b1;
      cyc();
      i_sof = 1'b0;
      set_exp(12'h401, FRAME);
      push_words(12'h401, FRAME);
      wait_writes(3, 30, "pre_reset");
      i_rstn = 1'b0;
      cyc();
      exp_q.delete();
      wr_idx = 0;
      i_rstn = 1'b1; i_enable = 1'b0;
      #1;
      chk_all_zero("midreset");
      nfd0 = nfd;
      repeat (10) cyc();
      chk("midreset_no_done", nfd - nfd0, 0);
      q.delete();
      i_enable = 1'b1; i_cfg_done = 1'b1;
      cyc();
      i_sof = 1'b1;
      cyc();
      i_sof = 1'b0;
      set_exp(12'h501, FRAME);
      push_words(12'h501, FRAME);
      wait_writes(FRAME, 40, "post_reset");
      chk("post_reset_done_cnt", nfd - nfd0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
